// File: rtl/seq_pattern_generator.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first, repeat_cnt+1 times.
// Define SEQGEN_GAP_EN to insert one idle GAP cycle between consecutive repetitions.
module seq_pattern_generator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  // Load handshake: a load happens on a rising edge where load_valid && load_ready.
  // load_ready is high only in IDLE; load_valid outside IDLE is ignored.
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             o,
  output logic             o_valid,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);

`ifdef SEQGEN_GAP_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] shift_q, hold_q, shift_d;
  logic [BW-1:0]    bit_cnt_q;
  logic [CNT_W-1:0] rep_q;
  logic             o_q, o_valid_q, last_q, busy_q, done_q;

  // shift_q[WIDTH-1] always mirrors the bit currently on o during SEND.
  assign shift_d    = shift_q << 1;
  assign load_ready = (state_q == IDLE);
  assign o          = o_q;
  assign o_valid    = o_valid_q;
  assign last       = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      hold_q    <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
      o_q       <= 1'b0;
      o_valid_q <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (load_valid) begin
            state_q   <= SEND;
            shift_q   <= pattern;
            hold_q    <= pattern;
            rep_q     <= repeat_cnt;
            bit_cnt_q <= BW'(WIDTH - 1);
            o_q       <= pattern[WIDTH-1];
            o_valid_q <= 1'b1;
            last_q    <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        SEND: begin
          if (abort || (bit_cnt_q == '0 && rep_q == '0)) begin
            state_q   <= DONE;
            o_q       <= 1'b0;
            o_valid_q <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else if (bit_cnt_q == '0) begin
            rep_q     <= rep_q - 1'b1;
            shift_q   <= hold_q;
            bit_cnt_q <= BW'(WIDTH - 1);
            last_q    <= 1'b0;
`ifdef SEQGEN_GAP_EN
            state_q   <= GAP;
            o_q       <= 1'b0;
            o_valid_q <= 1'b0;
`else
            o_q       <= hold_q[WIDTH-1];
            o_valid_q <= 1'b1;
`endif
          end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q - 1'b1;
            o_q       <= shift_q[WIDTH-2];
            last_q    <= (bit_cnt_q == BW'(1)) && (rep_q == '0);
          end
        end
`ifdef SEQGEN_GAP_EN
        GAP: begin
          if (abort) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            state_q   <= SEND;
            o_q       <= shift_q[WIDTH-1];
            o_valid_q <= 1'b1;
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Randomized bench for seq_pattern_generator; expected per-cycle outputs come from a stream model.
module tb_seq_pattern_generator;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic             abort = 1'b0;
  logic             o, o_valid, last, busy, done;

  int checks = 0;
  int errors = 0;

  // Expected vector per cycle: {load_ready, o_valid, o, last, busy, done}
  logic [5:0] exp_q[$];

  seq_pattern_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .abort(abort),
    .o(o), .o_valid(o_valid), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

`ifdef SEQGEN_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  // Builds the expected cycle stream of a burst; abort_at is the 1-based cycle
  // whose abort is sampled (0 = no abort).
  task automatic build_expected(input logic [WIDTH-1:0] pat, input int reps, input int abort_at);
    int n;
    exp_q.delete();
    n = 0;
    for (int r = 0; r <= reps; r++) begin
      if (r != 0 && GAP_EN) begin
        if (abort_at != 0 && n >= abort_at) break;
        exp_q.push_back(6'b0_0_0_0_1_0);
        n++;
      end
      for (int b = WIDTH - 1; b >= 0; b--) begin
        if (abort_at != 0 && n >= abort_at) break;
        exp_q.push_back({1'b0, 1'b1, pat[b], (r == reps && b == 0), 1'b1, 1'b0});
        n++;
      end
    end
    exp_q.push_back(6'b0_0_0_0_0_1);
  endtask

  // Loads one burst and checks every cycle until the block is back in IDLE.
  task automatic run_burst(input logic [WIDTH-1:0] pat, input int reps, input int abort_at,
                           input bit lv_hold, input string name);
    int wait_cnt;
    logic [5:0] act;
    wait_cnt = 0;
    while (!load_ready && wait_cnt < 40) begin
      @(posedge clk); @(negedge clk); wait_cnt++;
    end
    checks++;
    if (!load_ready) begin
      errors++;
      $display("FAIL %s ready_timeout load_ready=%0b required=1", name, load_ready);
    end
    build_expected(pat, reps, abort_at);
    pattern    = pat;
    repeat_cnt = CNT_W'(reps);
    load_valid = 1'b1;
    abort      = ($urandom_range(0, 1) == 1);
    @(posedge clk); @(negedge clk);
    for (int i = 1; exp_q.size() > 0; i++) begin
      act = {load_ready, o_valid, o, last, busy, done};
      checks++;
      if (act !== exp_q[0]) begin
        errors++;
        $display("FAIL %s cycle%0d {lr,ov,o,last,busy,done} actual=%b required=%b",
                 name, i, act, exp_q[0]);
      end
      void'(exp_q.pop_front());
      abort      = (i == abort_at);
      pattern    = WIDTH'($urandom);
      repeat_cnt = CNT_W'($urandom);
      load_valid = lv_hold ? 1'b1 : ($urandom_range(0, 1) == 1);
      @(posedge clk); @(negedge clk);
    end
    abort = 1'b0;
    act = {load_ready, o_valid, o, last, busy, done};
    checks++;
    if (act !== 6'b1_0_0_0_0_0) begin
      errors++;
      $display("FAIL %s idle_after {lr,ov,o,last,busy,done} actual=%b required=100000", name, act);
    end
    if (!lv_hold) load_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] act;
    rst = 1'b1;
    #12;
    act = {load_ready, o_valid, o, last, busy, done};
    checks++;
    if (act !== 6'b1_0_0_0_0_0) begin
      errors++;
      $display("FAIL reset_state actual=%b required=100000", act);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    run_burst(4'b0101, 0, 0, 1'b0, "single_0101");
    run_burst(4'b1001, 0, 0, 1'b0, "single_1001");
  endtask

  task automatic test_repeat();
    run_burst(4'b0101, 1, 0, 1'b0, "repeat_0101x2");
    run_burst(4'b1110, (1 << CNT_W) - 1, 0, 1'b0, "repeat_max");
    for (int k = 0; k < 6; k++)
      run_burst(WIDTH'($urandom), $urandom_range(0, 5), 0, 1'b0, "repeat_rand");
  endtask

  task automatic test_abort();
    run_burst(4'b1100, 3, 2, 1'b0, "abort_bit2");
    run_burst(4'b0110, 0, WIDTH, 1'b0, "abort_final_bit");
    run_burst(4'b0011, 2, WIDTH + 1, 1'b0, "abort_rep_boundary");
    for (int k = 0; k < 6; k++)
      run_burst(WIDTH'($urandom), 3, $urandom_range(1, 12), 1'b0, "abort_rand");
  endtask

  task automatic test_async_reset();
    logic [5:0] act;
    @(negedge clk);
    pattern = 4'b1111; repeat_cnt = 4'd5; load_valid = 1'b1;
    @(posedge clk); @(negedge clk); load_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    act = {load_ready, o_valid, o, last, busy, done};
    checks++;
    if (act !== 6'b1_0_0_0_0_0) begin
      errors++;
      $display("FAIL async_reset actual=%b required=100000", act);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_burst(4'b1010, 0, 0, 1'b0, "after_reset_1010");
  endtask

  task automatic test_back_to_back();
    run_burst(4'b0111, 1, 0, 1'b1, "b2b_first");
    run_burst(4'b1000, 0, 0, 1'b1, "b2b_second");
    run_burst(WIDTH'($urandom), 2, 0, 1'b0, "b2b_third");
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
